// File: rtl/fsmc_bridge_pkg.sv
// Shared encodings for the FSMC memory bridge: CLE commands, status bit
// positions (counted down from the data MSB) and the clear-engine state.
package fsmc_bridge_pkg;

    localparam logic [1:0] CMD_NOP      = 2'b00;
    localparam logic [1:0] CMD_AINC_ON  = 2'b01;
    localparam logic [1:0] CMD_AINC_OFF = 2'b10;
    localparam logic [1:0] CMD_CLEAR    = 2'b11;

    // Status flags sit at DATA_W-n so the word layout scales with DATA_W.
    localparam int ST_BUSY_OFS = 1;
    localparam int ST_AINC_OFS = 2;
    localparam int ST_WRAP_OFS = 3;
    localparam int ST_ERR_OFS  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/fsmc_edge_sync.sv
// Synchroniser chain plus history flop; reports the synchronised level and a
// one-clk pulse on the selected edge. All flops reset high (strobes idle high).
module fsmc_edge_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit RISE        = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign edge_o  = RISE ? (level_o & ~hist_q) : (~level_o & hist_q);

endmodule

// File: rtl/fsmc_mem_bridge.sv
// FSMC async bus to on-chip word memory bridge: ALE index load, CLE command /
// status channel, auto-increment with sticky wrap, and a background clear engine.
module fsmc_mem_bridge
    import fsmc_bridge_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              noe,
    input  logic              nwe,
    input  logic              nce,
    input  logic              ale,
    input  logic              cle,
    inout  wire  [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] index_o,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic noe_lvl, noe_fall;
    logic nwe_lvl_unused, nwe_rise;

    fsmc_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RISE(1'b0)) u_noe_sync (
        .clk    (clk),
        .rst_n  (reset_l),
        .async_i(noe),
        .level_o(noe_lvl),
        .edge_o (noe_fall)
    );

    fsmc_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RISE(1'b1)) u_nwe_sync (
        .clk    (clk),
        .rst_n  (reset_l),
        .async_i(nwe),
        .level_o(nwe_lvl_unused),
        .edge_o (nwe_rise)
    );

    state_e            state_q;
    logic [ADDR_W-1:0] index_q, clr_ptr_q;
    logic              autoinc_q, wrap_q, err_q, busy_q, sel_mem_q;
    logic [DATA_W-1:0] latch_q, mem_rd_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] data_in;
    logic [1:0]        cmd;
    logic              rd_evt, wr_evt;
    logic              wr_ale, wr_cmd, wr_dat, rd_stat, rd_mem;
    logic              clr_cmd;
    logic [ADDR_W-1:0] index_inc;
    logic              index_at_top;

    assign data_in = data;
    assign cmd     = data_in[1:0];

    // ale/cle/data are only trusted on the wr_evt cycle; FSMC hold covers it.
    assign rd_evt  = noe_fall & ~nce;
    assign wr_evt  = nwe_rise & ~nce;
    assign wr_ale  = wr_evt & ale;
    assign wr_cmd  = wr_evt & ~ale & cle;
    assign wr_dat  = wr_evt & ~ale & ~cle;
    assign rd_stat = rd_evt & ~wr_evt & cle;
    assign rd_mem  = rd_evt & ~wr_evt & ~cle;
    assign clr_cmd = wr_cmd & (cmd == CMD_CLEAR);

    assign index_inc    = index_q + 1'b1;
    assign index_at_top = &index_q;

    function automatic logic [DATA_W-1:0] status_word(
        input logic              b,
        input logic              ai,
        input logic              wr,
        input logic              er,
        input logic [ADDR_W-1:0] idx
    );
        logic [DATA_W-1:0] s;
        s                     = '0;
        s[DATA_W-ST_BUSY_OFS] = b;
        s[DATA_W-ST_AINC_OFS] = ai;
        s[DATA_W-ST_WRAP_OFS] = wr;
        s[DATA_W-ST_ERR_OFS]  = er;
        s[ADDR_W-1:0]         = idx;
        return s;
    endfunction

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q   <= IDLE;
            index_q   <= '0;
            clr_ptr_q <= '0;
            autoinc_q <= 1'b1;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            sel_mem_q <= 1'b0;
            latch_q   <= '0;
        end else begin
            // Clear engine runs first so a fresh CLEAR command below overrides it.
            if (state_q == CLEAR) begin
                clr_ptr_q <= clr_ptr_q + 1'b1;
                if (&clr_ptr_q) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            end

            if (wr_ale) begin
                index_q <= data_in[ADDR_W-1:0];
                wrap_q  <= 1'b0;
            end else if (wr_cmd) begin
                case (cmd)
                    CMD_AINC_ON:  autoinc_q <= 1'b1;
                    CMD_AINC_OFF: autoinc_q <= 1'b0;
                    CMD_CLEAR: begin
                        state_q   <= CLEAR;
                        clr_ptr_q <= '0;
                        busy_q    <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (wr_dat) begin
                if (state_q == IDLE) begin
                    if (autoinc_q) begin
                        index_q <= index_inc;
                        if (index_at_top) wrap_q <= 1'b1;
                    end
                end else begin
                    err_q <= 1'b1;
                end
            end else if (rd_stat) begin
                latch_q   <= status_word(busy_q, autoinc_q, wrap_q, err_q, index_q);
                sel_mem_q <= 1'b0;
                err_q     <= 1'b0;
            end else if (rd_mem) begin
                if (state_q == IDLE) begin
                    sel_mem_q <= 1'b1;
                    if (autoinc_q) begin
                        index_q <= index_inc;
                        if (index_at_top) wrap_q <= 1'b1;
                    end
                end else begin
                    latch_q   <= '0;
                    sel_mem_q <= 1'b0;
                end
            end
        end
    end

    // Single write port shared by host and clear engine; they never collide
    // because host data writes are dropped while clearing.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign mem_we    = (state_q == CLEAR) | (wr_dat & (state_q == IDLE));
    assign mem_waddr = (state_q == CLEAR) ? clr_ptr_q : index_q;
    assign mem_wdata = (state_q == CLEAR) ? '0 : data_in;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (rd_mem && state_q == IDLE) mem_rd_q <= mem[index_q];
    end

    logic [DATA_W-1:0] dout;
    assign dout = sel_mem_q ? mem_rd_q : latch_q;
    assign data = (~noe_lvl & ~nce) ? dout : {DATA_W{1'bz}};

    assign index_o = index_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_fsmc_mem_bridge.sv
// Bench for fsmc_mem_bridge: FSMC host tasks, table of bus vectors with a read
// scoreboard, and hand sequences for clear, chip-select gating and async reset.
module tb_fsmc_mem_bridge;

    localparam int DW = 16;
    localparam int AW = 9;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset_l = 1'b0;
    logic          noe = 1'b1, nwe = 1'b1, nce = 1'b1, ale = 1'b0, cle = 1'b0;
    logic          hoe = 1'b0;
    logic [DW-1:0] hdata = '0;
    wire  [DW-1:0] data;
    logic [AW-1:0] index_o;
    logic          busy;

    assign data = hoe ? hdata : {DW{1'bz}};

    always #5 clk = ~clk;

    fsmc_mem_bridge #(.DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(SS)) dut (
        .clk    (clk),
        .reset_l(reset_l),
        .noe    (noe),
        .nwe    (nwe),
        .nce    (nce),
        .ale    (ale),
        .cle    (cle),
        .data   (data),
        .index_o(index_o),
        .busy   (busy)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    typedef enum {V_ALE, V_CMD, V_WR, V_RD, V_STAT} vop_e;
    typedef struct {
        vop_e          op;
        logic [DW-1:0] d;
        logic [DW-1:0] exp;
        logic [AW-1:0] idx;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic add(input vop_e op, input logic [DW-1:0] d, input logic [DW-1:0] e,
                       input logic [AW-1:0] idx);
        vec_t v;
        v.op = op; v.d = d; v.exp = e; v.idx = idx;
        vecs.push_back(v);
    endtask

    // Strobe low for 3 clk, then hold ale/cle/data well past the synchronised rise.
    task automatic fsmc_wr(input bit a, input bit c, input logic [DW-1:0] d, input bit cs);
        @(negedge clk);
        nce = ~cs; ale = a; cle = c; hdata = d; hoe = 1'b1; nwe = 1'b0;
        repeat (3) @(negedge clk);
        nwe = 1'b1;
        repeat (SS + 3) @(negedge clk);
        hoe = 1'b0; ale = 1'b0; cle = 1'b0; nce = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic fsmc_rd(input bit c, input bit cs, output logic [DW-1:0] got);
        @(negedge clk);
        nce = ~cs; cle = c; noe = 1'b0;
        repeat (SS + 3) @(negedge clk);
        got = data;
        noe = 1'b1;
        repeat (SS + 2) @(negedge clk);
        cle = 1'b0; nce = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_read(input bit c, input logic [DW-1:0] e, input string nm);
        logic [DW-1:0] got;
        exp_q.push_back(e);
        fsmc_rd(c, 1'b1, got);
        check(nm, got, exp_q.pop_front());
    endtask

    task automatic wait_idle(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        check(nm, {15'b0, done}, 16'h0001);
    endtask

    initial begin
        logic [DW-1:0] got;
        int            cnt;
        bit            seen;

        // Basic access, wrap, autoinc on/off, command upper bits ignored.
        add(V_ALE,  16'h0005, 16'h0000, 9'h005);
        add(V_WR,   16'hA5A5, 16'h0000, 9'h006);
        add(V_WR,   16'h5A5A, 16'h0000, 9'h007);
        add(V_ALE,  16'h0005, 16'h0000, 9'h005);
        add(V_RD,   16'h0000, 16'hA5A5, 9'h006);
        add(V_RD,   16'h0000, 16'h5A5A, 9'h007);
        add(V_ALE,  16'h01FF, 16'h0000, 9'h1FF);
        add(V_WR,   16'h1234, 16'h0000, 9'h000);
        add(V_WR,   16'h4321, 16'h0000, 9'h001);
        add(V_STAT, 16'h0000, 16'h6001, 9'h001);
        add(V_ALE,  16'h01FF, 16'h0000, 9'h1FF);
        add(V_STAT, 16'h0000, 16'h41FF, 9'h1FF);
        add(V_RD,   16'h0000, 16'h1234, 9'h000);
        add(V_RD,   16'h0000, 16'h4321, 9'h001);
        add(V_STAT, 16'h0000, 16'h6001, 9'h001);
        add(V_ALE,  16'h0010, 16'h0000, 9'h010);
        add(V_WR,   16'hBEEF, 16'h0000, 9'h011);
        add(V_ALE,  16'h0010, 16'h0000, 9'h010);
        add(V_CMD,  16'h0002, 16'h0000, 9'h010);
        add(V_RD,   16'h0000, 16'hBEEF, 9'h010);
        add(V_RD,   16'h0000, 16'hBEEF, 9'h010);
        add(V_RD,   16'h0000, 16'hBEEF, 9'h010);
        add(V_STAT, 16'h0000, 16'h0010, 9'h010);
        add(V_CMD,  16'hFFF1, 16'h0000, 9'h010);
        add(V_STAT, 16'h0000, 16'h4010, 9'h010);
        add(V_CMD,  16'h0000, 16'h0000, 9'h010);
        add(V_STAT, 16'h0000, 16'h4010, 9'h010);

        repeat (3) @(negedge clk);
        check("reset_index", {7'b0, index_o}, 16'h0000);
        check("reset_busy", {15'b0, busy}, 16'h0000);
        reset_l = 1'b1;
        repeat (2) @(negedge clk);
        do_read(1'b1, 16'h4000, "reset_status");

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                V_ALE:  fsmc_wr(1'b1, 1'b0, vecs[i].d, 1'b1);
                V_CMD:  fsmc_wr(1'b0, 1'b1, vecs[i].d, 1'b1);
                V_WR:   fsmc_wr(1'b0, 1'b0, vecs[i].d, 1'b1);
                V_RD:   do_read(1'b0, vecs[i].exp, $sformatf("vec%0d_rd", i));
                V_STAT: do_read(1'b1, vecs[i].exp, $sformatf("vec%0d_stat", i));
                default: ;
            endcase
            check($sformatf("vec%0d_idx", i), {7'b0, index_o}, {7'b0, vecs[i].idx});
        end

        // Fill everything, then clear with host traffic while the engine runs.
        fsmc_wr(1'b1, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 512; i++) fsmc_wr(1'b0, 1'b0, 16'hFFFF, 1'b1);
        check("fill_idx_wrapped", {7'b0, index_o}, 16'h0000);
        fsmc_wr(1'b1, 1'b0, 16'h0020, 1'b1);
        fsmc_wr(1'b0, 1'b1, 16'h0003, 1'b1);
        check("clr_busy_set", {15'b0, busy}, 16'h0001);
        do_read(1'b0, 16'h0000, "clr_read_zero");
        check("clr_read_idx", {7'b0, index_o}, 16'h0020);
        fsmc_wr(1'b0, 1'b0, 16'h7777, 1'b1);
        check("clr_drop_idx", {7'b0, index_o}, 16'h0020);
        do_read(1'b1, 16'hD020, "clr_status_err");
        do_read(1'b1, 16'hC020, "clr_status_err_cleared");
        wait_idle("clr_finish");
        fsmc_wr(1'b1, 1'b0, 16'h0000, 1'b1);
        cnt = 0;
        for (int i = 0; i < 512; i++) begin
            fsmc_rd(1'b0, 1'b1, got);
            if (got !== 16'h0000) cnt++;
        end
        check("clr_all_zero_bad_words", cnt[DW-1:0], 16'h0000);
        check("clr_readback_idx", {7'b0, index_o}, 16'h0000);

        // Busy width: count negedges with busy high from the CLEAR strobe on.
        @(negedge clk);
        nce = 1'b0; cle = 1'b1; hdata = 16'h0003; hoe = 1'b1; nwe = 1'b0;
        repeat (3) @(negedge clk);
        nwe = 1'b1;
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (busy) begin cnt++; seen = 1'b1; end
            else if (seen) break;
        end
        hoe = 1'b0; cle = 1'b0; nce = 1'b1;
        check("clr_busy_width", cnt[DW-1:0], 16'd512);

        // Chip select high: strobes must be ignored.
        fsmc_wr(1'b1, 1'b0, 16'h0030, 1'b1);
        fsmc_wr(1'b0, 1'b0, 16'h1111, 1'b1);
        fsmc_wr(1'b1, 1'b0, 16'h0030, 1'b1);
        fsmc_wr(1'b1, 1'b0, 16'h0100, 1'b0);
        fsmc_wr(1'b0, 1'b0, 16'h2222, 1'b0);
        fsmc_wr(1'b0, 1'b1, 16'h0003, 1'b0);
        fsmc_rd(1'b0, 1'b0, got);
        check("nce_idx", {7'b0, index_o}, 16'h0030);
        check("nce_busy", {15'b0, busy}, 16'h0000);
        do_read(1'b0, 16'h1111, "nce_mem_intact");

        // Async reset in the middle of a clear.
        fsmc_wr(1'b1, 1'b0, 16'h0055, 1'b1);
        fsmc_wr(1'b0, 1'b1, 16'h0003, 1'b1);
        repeat (10) @(negedge clk);
        #2 reset_l = 1'b0;
        #1;
        check("rst_mid_busy", {15'b0, busy}, 16'h0000);
        check("rst_mid_idx", {7'b0, index_o}, 16'h0000);
        @(negedge clk);
        reset_l = 1'b1;
        repeat (3) @(negedge clk);
        do_read(1'b1, 16'h4000, "rst_mid_status");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
